sram16_target: RTL and testbench
================================

Name: sram16_target

Overview:
- Memory-side responder for the core's load/store unit: accepts word-aligned requests (30-bit word address, 4-bit byte enables, 32-bit lane-aligned write data) and returns 32-bit raw read words.
- Byte-lane extraction and sign extension stay in the core.
- Drives an external asynchronous 16-bit SRAM by splitting each word into a low-halfword phase and a high-halfword phase, using registered strobes and programmable wait states.

Parameters:
- WAIT_CYCLES, 1, strobe-active cycles per halfword phase; legal values are 1 and above.
- SRAM_AW, 18, SRAM halfword address width.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  block idle; a request is accepted on a clk edge where req_valid and req_ready are both high.
- req_addr  in  30  word address.
- req_we  in  4  byte write enables; 4'b0000 means a read.
- req_wdata  in  32  write data, already lane-aligned.
- resp_valid  out  1  one-cycle completion pulse, for both reads and writes.
- resp_rdata  out  32  read word.
- sram_addr  out  SRAM_AW  halfword address.
- sram_dq_out  out  16  write data to pads.
- sram_dq_oe  out  1  pad output enable.
- sram_dq_in  in  16  read data from pads.
- sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n  out  1 each  SRAM strobes, active-low.

Behaviour:
- Reset (async, resetn=0):
  - State is IDLE and req_ready=1.
  - resp_valid=0 and resp_rdata=0.
  - All strobes are 1 and sram_dq_oe=0.
  - sram_addr=0 and sram_dq_out=0.
  - All outputs are registered. No combinational path from any input to any output.
- States: IDLE, LO_ACT, LO_REC, HI_ACT, HI_REC, RESP.
- IDLE:
  - req_ready=1.
  - On accept, latch addr, we and wdata internally. req_ready drops the next cycle.
  - Request inputs are ignored outside accept cycles.
- Phase selection:
  - A read runs LO then HI.
  - A write runs the LO phase only if we[1:0]!=0, and the HI phase only if we[3:2]!=0.
  - A write that needs no phase cannot occur, because we=0 is a read.
- Phase setup:
  - At the start of a phase's ACT state, sram_addr = {addr[SRAM_AW-2:0], h}, with h=0 for LO and h=1 for HI.
  - sram_dq_out = wdata[15:0] for LO, wdata[31:16] for HI.
  - Address and data are held constant through that phase's ACT and REC states.
- ACT state:
  - Lasts exactly WAIT_CYCLES cycles, counted by a down-counter.
  - sram_ce_n=0.
  - Read: sram_oe_n=0, sram_ub_n=0, sram_lb_n=0.
  - Write: sram_we_n=0, sram_dq_oe=1, sram_lb_n=~we[0] (LO) or ~we[2] (HI), sram_ub_n=~we[1] (LO) or ~we[3] (HI).
- REC state:
  - Lasts 1 cycle.
  - sram_oe_n=1, sram_we_n=1, sram_ce_n=0.
  - The ub/lb enables and sram_dq_oe keep their ACT values, giving write hold time.
- Read capture:
  - sram_dq_in is sampled on the clk edge that ends the last ACT cycle.
  - The LO sample goes to resp_rdata[15:0]; the HI sample goes to resp_rdata[31:16].
  - resp_rdata is unchanged by writes.
- RESP:
  - Lasts 1 cycle with resp_valid=1, then returns to IDLE with req_ready=1.
  - Minimum request-to-request spacing is therefore latency+1 cycles.
- Latency, counted in cycles from the accept edge to the resp_valid cycle:
  - Two-phase operation: 2*(WAIT_CYCLES+1)+1.
  - One-phase write: (WAIT_CYCLES+1)+1.
- Outside ACT and REC: all strobes are 1 and sram_dq_oe=0.
- Reset asserted mid-operation:
  - Strobes release immediately.
  - The in-flight request is dropped with no resp_valid.
  - resp_rdata is cleared.
- Address bits req_addr[29:SRAM_AW-1] are ignored (aliasing).

Test Plan:
- Read, WAIT_CYCLES=1, addr=0x10, SRAM halfwords 0x20=0xBEEF and 0x21=0xDEAD.
  - resp_valid high exactly 5 cycles after accept, with resp_rdata=0xDEADBEEF.
  - oe_n is low 1 cycle per phase; sram_addr is 0x20, then 0x21.
- Write we=1111, wdata=0x12345678, addr=3.
  - Halfword 6 is written with 0x5678, then halfword 7 with 0x1234.
  - ub_n=lb_n=0 in both phases; we_n low 1 cycle each; resp_valid at cycle 5.
- Write we=0100, wdata=0x00AB0000.
  - LO phase is skipped. HI phase only, with ub_n=1 and lb_n=0, dq_out=0x00AB.
  - resp_valid at cycle 3; a readback returns bits [23:16]=0xAB with other bytes unchanged.
- WAIT_CYCLES=3 read.
  - oe_n low 3 consecutive cycles per phase; resp_valid at cycle 9.
  - sram_dq_in changes before the final ACT edge are not captured.
- Back-to-back: req_valid held high with two reads queued.
  - req_ready low from the cycle after accept through RESP; second accept on the cycle after RESP.
  - Each resp_valid is 1 cycle wide.
- resetn pulsed low during the HI_ACT of a write.
  - we_n, ce_n and dq_oe release asynchronously with no resp_valid.
  - req_ready=1 after resetn rises, and the next read completes normally.

Source files
------------

// File: rtl/sram16_target.sv
// sram16_target: word-wide load/store responder driving a 16-bit async SRAM
// as a low then high halfword phase with registered strobes and wait states.
module sram16_target #(
  parameter int WAIT_CYCLES = 1,
  parameter int SRAM_AW = 18
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [29:0]        req_addr,
  input  logic [3:0]         req_we,
  input  logic [31:0]        req_wdata,
  output logic               resp_valid,
  output logic [31:0]        resp_rdata,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [15:0]        sram_dq_out,
  output logic               sram_dq_oe,
  input  logic [15:0]        sram_dq_in,
  output logic               sram_ce_n,
  output logic               sram_oe_n,
  output logic               sram_we_n,
  output logic               sram_ub_n,
  output logic               sram_lb_n
);
  localparam int CW = $clog2(WAIT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, LO_ACT, LO_REC, HI_ACT, HI_REC, RESP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [SRAM_AW-2:0] addr_q, a_s;
  logic [3:0] we_q, we_s;
  logic [31:0] wdata_q, wd_s;
  logic [1:0] be;
  logic rd, hi, start;
  logic unused;
  assign unused = ^req_addr[29:SRAM_AW-1];
  // In IDLE the phase is set up straight from the request so ACT begins right after accept.
  always_comb begin
    we_s = (state == IDLE) ? req_we : we_q;
    wd_s = (state == IDLE) ? req_wdata : wdata_q;
    a_s = (state == IDLE) ? req_addr[SRAM_AW-2:0] : addr_q;
    rd = we_s == 4'b0;
    hi = (state == LO_REC) || (!rd && we_s[1:0] == 2'b0);
    be = hi ? we_s[3:2] : we_s[1:0];
    start = (state == IDLE && req_valid) || (state == LO_REC && (rd || we_s[3:2] != 2'b0));
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      we_q <= '0;
      wdata_q <= '0;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      sram_addr <= '0;
      sram_dq_out <= '0;
      sram_dq_oe <= 1'b0;
      sram_ce_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_we_n <= 1'b1;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
    end else begin
      resp_valid <= 1'b0;
      if (start) begin
        if (state == IDLE) begin
          addr_q <= req_addr[SRAM_AW-2:0];
          we_q <= req_we;
          wdata_q <= req_wdata;
        end
        state <= hi ? HI_ACT : LO_ACT;
        cnt <= CW'(WAIT_CYCLES - 1);
        req_ready <= 1'b0;
        sram_addr <= {a_s, hi};
        sram_dq_out <= hi ? wd_s[31:16] : wd_s[15:0];
        sram_ce_n <= 1'b0;
        sram_oe_n <= !rd;
        sram_we_n <= rd;
        sram_dq_oe <= !rd;
        sram_ub_n <= rd ? 1'b0 : !be[1];
        sram_lb_n <= rd ? 1'b0 : !be[0];
      end else begin
        case (state)
          LO_ACT, HI_ACT:
            if (cnt != '0) cnt <= cnt - 1'b1;
            else begin
              state <= (state == LO_ACT) ? LO_REC : HI_REC;
              sram_oe_n <= 1'b1;
              sram_we_n <= 1'b1;
              if (rd && state == LO_ACT) resp_rdata[15:0] <= sram_dq_in;
              if (rd && state == HI_ACT) resp_rdata[31:16] <= sram_dq_in;
            end
          LO_REC, HI_REC: begin
            state <= RESP;
            resp_valid <= 1'b1;
            sram_ce_n <= 1'b1;
            sram_ub_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_dq_oe <= 1'b0;
          end
          RESP: begin
            state <= IDLE;
            req_ready <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sram16_target.sv
// tb_sram16_target: checks sram16_target against a cycle-trace model built from
// the phase rules, with a behavioural async SRAM on the pads.
module tb_sram16_target;
  logic clk = 1'b0, resetn = 1'b1;
  always #5 clk = ~clk;
  logic req_valid1, req_valid2;
  logic [29:0] req_addr;
  logic [3:0] req_we;
  logic [31:0] req_wdata;
  logic ready1, rv1, dq_oe1, ce1, oe1, we1, ub1, lb1;
  logic ready2, rv2, dq_oe2, ce2, oe2, we2, ub2, lb2;
  logic [31:0] rdata1, rdata2;
  logic [17:0] addr1, addr2;
  logic [15:0] dq_out1, dq_out2, dq_in1, dq_in2;
  sram16_target #(.WAIT_CYCLES(1), .SRAM_AW(18)) dut1 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid1), .req_ready(ready1),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(rv1), .resp_rdata(rdata1), .sram_addr(addr1), .sram_dq_out(dq_out1),
    .sram_dq_oe(dq_oe1), .sram_dq_in(dq_in1), .sram_ce_n(ce1), .sram_oe_n(oe1),
    .sram_we_n(we1), .sram_ub_n(ub1), .sram_lb_n(lb1));
  sram16_target #(.WAIT_CYCLES(3), .SRAM_AW(18)) dut2 (
    .clk(clk), .resetn(resetn), .req_valid(req_valid2), .req_ready(ready2),
    .req_addr(req_addr), .req_we(req_we), .req_wdata(req_wdata),
    .resp_valid(rv2), .resp_rdata(rdata2), .sram_addr(addr2), .sram_dq_out(dq_out2),
    .sram_dq_oe(dq_oe2), .sram_dq_in(dq_in2), .sram_ce_n(ce2), .sram_oe_n(oe2),
    .sram_we_n(we2), .sram_ub_n(ub2), .sram_lb_n(lb2));

  // Pad-side SRAM: preloaded 0x20/0x21, writes land while ce_n and we_n are low at a clock edge.
  bit [15:0] pad_mem [1024];
  bit pad_wr [1024];
  always_comb
    dq_in1 = (!ce1 && !oe1) ? (pad_wr[addr1[9:0]] ? pad_mem[addr1[9:0]] :
             addr1 == 18'h20 ? 16'hBEEF : addr1 == 18'h21 ? 16'hDEAD : 16'h0) : 16'h0;
  always @(posedge clk)
    if (!ce1 && !we1) begin
      pad_wr[addr1[9:0]] <= 1'b1;
      if (!lb1) pad_mem[addr1[9:0]][7:0] <= dq_out1[7:0];
      if (!ub1) pad_mem[addr1[9:0]][15:8] <= dq_out1[15:8];
    end

  typedef struct packed {
    bit rdy, rv, ce, oe, we, ub, lb, oen;
    bit ca; bit [17:0] a;
    bit cd; bit [15:0] d;
    bit cr; bit [31:0] r;
  } exp_t;
  exp_t q[$];
  exp_t cur;
  bit [15:0] ref_mem [1024];
  logic [31:0] m_rdata = 0, last_r = 0;
  bit mon_en = 0;
  int total = 0, bad = 0;

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %h want %h", n, $time, act, exp);
    end
  endfunction

  function automatic exp_t idle_e(input logic [31:0] r);
    exp_t e;
    e = '0;
    e.rdy = 1; e.ce = 1; e.oe = 1; e.we = 1; e.ub = 1; e.lb = 1;
    e.cr = 1; e.r = r;
    return e;
  endfunction

  // Expected per-cycle outputs from the accept cycle through RESP for the WAIT_CYCLES=1 instance.
  task automatic build(input [29:0] a, input [3:0] we, input [31:0] wd);
    bit rd;
    bit [1:0] be;
    bit [17:0] ha;
    bit [15:0] hv [2];
    exp_t e;
    rd = (we == 4'b0);
    hv[0] = 0; hv[1] = 0;
    q.push_back(idle_e(m_rdata));
    for (int h = 0; h < 2; h++) begin
      be = h[0] ? we[3:2] : we[1:0];
      if (rd || be != 2'b0) begin
        ha = {a[16:0], h[0]};
        e = idle_e(0);
        e.rdy = 0; e.ce = 0; e.oe = !rd; e.we = rd; e.oen = !rd;
        e.ub = rd ? 1'b0 : ~be[1];
        e.lb = rd ? 1'b0 : ~be[0];
        e.ca = 1; e.a = ha; e.cd = !rd; e.d = h[0] ? wd[31:16] : wd[15:0]; e.cr = 0;
        q.push_back(e);
        e.oe = 1; e.we = 1;
        q.push_back(e);
        if (rd) hv[h] = ref_mem[ha[9:0]];
        else begin
          if (be[0]) ref_mem[ha[9:0]][7:0] = e.d[7:0];
          if (be[1]) ref_mem[ha[9:0]][15:8] = e.d[15:8];
        end
      end
    end
    if (rd) m_rdata = {hv[1], hv[0]};
    e = idle_e(m_rdata);
    e.rdy = 0; e.rv = 1;
    q.push_back(e);
  endtask

  always @(negedge clk)
    if (mon_en) begin
      cur = (q.size() != 0) ? q.pop_front() : idle_e(last_r);
      chk("ready", ready1, cur.rdy);
      chk("resp_valid", rv1, cur.rv);
      chk("ce_n", ce1, cur.ce);
      chk("oe_n", oe1, cur.oe);
      chk("we_n", we1, cur.we);
      chk("ub_n", ub1, cur.ub);
      chk("lb_n", lb1, cur.lb);
      chk("dq_oe", dq_oe1, cur.oen);
      if (cur.ca) chk("addr", addr1, cur.a);
      if (cur.cd) chk("dq_out", dq_out1, cur.d);
      if (cur.cr) begin
        chk("rdata", rdata1, cur.r);
        last_r = cur.r;
      end
    end

  task automatic issue(input [29:0] a, input [3:0] we, input [31:0] wd, input bit keep);
    req_valid1 = 1; req_addr = a; req_we = we; req_wdata = wd;
    build(a, we, wd);
    @(posedge clk); #1;
    if (!keep) req_valid1 = 0;
  endtask

  task automatic finish_op(input string n, input int want_lat);
    int lat;
    bit seen;
    lat = 0; seen = 0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      seen = rv1;
    end
    chk({n, "_latency"}, lat, want_lat);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req_valid1 = 0; req_valid2 = 0; req_addr = 0; req_we = 0; req_wdata = 0; dq_in2 = 0;
    ref_mem[32] = 16'hBEEF;
    ref_mem[33] = 16'hDEAD;
    #2 resetn = 0;
    #1;
    chk("rst_ready", ready1, 1);
    chk("rst_rv", rv1, 0);
    chk("rst_rdata", rdata1, 0);
    chk("rst_strobes", {ce1, oe1, we1, ub1, lb1}, 5'b11111);
    chk("rst_dq_oe", dq_oe1, 0);
    chk("rst_addr", addr1, 0);
    chk("rst_dq_out", dq_out1, 0);
    repeat (2) @(posedge clk);
    @(negedge clk); #2 resetn = 1;
    @(posedge clk); #1;
    mon_en = 1;

    issue(30'h10, 4'b0000, 32'h0, 0);
    finish_op("rd10", 5);
    chk("rd10_data", rdata1, 32'hDEADBEEF);
    issue(30'h3, 4'b1111, 32'h12345678, 0);
    finish_op("wr3", 5);
    chk("mem6", pad_mem[6], 16'h5678);
    chk("mem7", pad_mem[7], 16'h1234);
    chk("wr_keeps_rdata", rdata1, 32'hDEADBEEF);
    issue(30'h3, 4'b0100, 32'h00AB0000, 0);
    finish_op("wr3hi", 3);
    chk("mem7_hi", pad_mem[7], 16'h12AB);
    chk("mem6_hi", pad_mem[6], 16'h5678);
    issue(30'h3, 4'b0000, 32'h0, 0);
    finish_op("rd3", 5);
    chk("rd3_data", rdata1, 32'h12AB5678);
    issue(30'h3, 4'b0001, 32'hFFFF00CC, 0);
    finish_op("wr3lo", 3);
    chk("mem6_lo", pad_mem[6], 16'h56CC);

    // Back-to-back reads with req_valid held high across the first operation.
    issue(30'h10, 4'b0000, 32'h0, 1);
    finish_op("b2b1", 5);
    chk("b2b1_data", rdata1, 32'hDEADBEEF);
    issue(30'h3, 4'b0000, 32'h0, 0);
    finish_op("b2b2", 5);
    chk("b2b2_data", rdata1, 32'h12AB56CC);
    issue(30'h2000_0010, 4'b0000, 32'h0, 0);
    finish_op("alias", 5);
    chk("alias_data", rdata1, 32'hDEADBEEF);

    // Three wait states: pad data changes every cycle, only the last ACT cycle is captured.
    req_valid2 = 1; req_addr = 30'h5; req_we = 0; dq_in2 = 16'h1000;
    @(posedge clk); #1;
    req_valid2 = 0;
    for (int k = 1; k <= 9; k++) begin
      dq_in2 = 16'h1000 + 16'(k);
      @(negedge clk);
      chk("w3_oe_n", oe2, (k inside {[1:3], [5:7]}) ? 32'd0 : 32'd1);
      chk("w3_resp_valid", rv2, (k == 9) ? 32'd1 : 32'd0);
      chk("w3_ready", ready2, 0);
      if (k == 1) chk("w3_addr_lo", addr2, 18'h0A);
      if (k == 5) chk("w3_addr_hi", addr2, 18'h0B);
      @(posedge clk); #1;
    end
    chk("w3_data", rdata2, 32'h10071003);
    chk("w3_ready_after", ready2, 1);

    // Reset during the HI ACT of a full-word write.
    mon_en = 0;
    req_valid1 = 1; req_addr = 30'h40; req_we = 4'hF; req_wdata = 32'hCAFEF00D;
    @(posedge clk); #1;
    req_valid1 = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_pre_we_n", we1, 0);
    chk("rst_pre_addr", addr1, 18'h81);
    chk("rst_pre_dq_out", dq_out1, 16'hCAFE);
    #2 resetn = 0;
    #1;
    chk("rst_mid_we_n", we1, 1);
    chk("rst_mid_ce_n", ce1, 1);
    chk("rst_mid_dq_oe", dq_oe1, 0);
    chk("rst_mid_rv", rv1, 0);
    chk("rst_mid_rdata", rdata1, 0);
    chk("rst_mid_ready", ready1, 1);
    chk("rst_mem80", pad_mem[10'h80], 16'hF00D);
    chk("rst_mem81", pad_mem[10'h81], 16'h0);
    ref_mem[10'h80] = 16'hF00D;
    q.delete();
    m_rdata = 0;
    last_r = 0;
    @(negedge clk); #2 resetn = 1;
    @(posedge clk); #1;
    chk("rst_post_ready", ready1, 1);
    mon_en = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_no_resp", rv1, 0);
    end
    @(posedge clk); #1;
    issue(30'h40, 4'b0000, 32'h0, 0);
    finish_op("rd_after_rst", 5);
    chk("rd_after_rst_data", rdata1, 32'h0000F00D);
    repeat (2) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
